// File: rtl/mws_pkg.sv
// Shared types and constants for the multi-word add/subtract sequencer.
package mws_pkg;

    localparam int CHUNK_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Chunk-index width; never zero so a 1-bit counter still exists.
    function automatic int idx_w(input int words);
        return (words <= 2) ? 1 : $clog2(words);
    endfunction

endpackage

// File: rtl/carry_select_adder_16bit.sv
// 16-bit carry-select adder: ripple low byte, precomputed high byte for both carries.
module carry_select_adder_16bit (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic [15:0] sum,
    output logic        cout
);

    logic [8:0] lo;
    logic [8:0] hi0;
    logic [8:0] hi1;

    always_comb begin
        lo   = {1'b0, a[7:0]} + {1'b0, b[7:0]} + {8'd0, cin};
        hi0  = {1'b0, a[15:8]} + {1'b0, b[15:8]};
        hi1  = hi0 + 9'd1;
        sum  = {(lo[8] ? hi1[7:0] : hi0[7:0]), lo[7:0]};
        cout = lo[8] ? hi1[8] : hi0[8];
    end

endmodule

// File: rtl/multiword_add_sequencer.sv
// Wide add/subtract sequenced one 16-bit chunk per cycle (LSB first) through a
// single shared carry-select adder, with valid/ready handshakes on both sides.
module multiword_add_sequencer
    import mws_pkg::*;
#(
    parameter int WORDS = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [16*WORDS-1:0]    in_a,
    input  logic [16*WORDS-1:0]    in_b,
    input  logic                   in_cin,
    input  logic                   in_sub,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [16*WORDS-1:0]    out_sum,
    output logic                   out_cout,
    output logic                   out_ovf,
    output logic                   busy
);

    localparam int IDX_W = idx_w(WORDS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

    state_t                           state_q, state_d;
    logic [IDX_W-1:0]                 idx_q, idx_d;
    logic                             carry_q, carry_d;
    logic [WORDS-1:0][CHUNK_W-1:0]    a_q, a_d;
    logic [WORDS-1:0][CHUNK_W-1:0]    b_q, b_d;
    logic [WORDS-1:0][CHUNK_W-1:0]    work_q, work_d;
    logic [WORDS-1:0][CHUNK_W-1:0]    sum_q, sum_d;
    logic                             cout_q, cout_d;
    logic                             ovf_q, ovf_d;
    logic                             valid_q, valid_d;

    logic [CHUNK_W-1:0]               add_a;
    logic [CHUNK_W-1:0]               add_b;
    logic [CHUNK_W-1:0]               add_sum;
    logic                             add_cout;

    assign add_a = a_q[idx_q];
    assign add_b = b_q[idx_q];

    carry_select_adder_16bit u_adder (
        .a    (add_a),
        .b    (add_b),
        .cin  (carry_q),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // Reset holds the state at IDLE, so acceptance is also gated by rst itself.
    assign in_ready  = (state_q == IDLE) && !rst;
    assign busy      = (state_q != IDLE);
    assign out_valid = valid_q;
    assign out_sum   = sum_q;
    assign out_cout  = cout_q;
    assign out_ovf   = ovf_q;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        work_d  = work_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        valid_d = valid_q;

        case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    a_d     = in_a;
                    b_d     = in_sub ? ~in_b : in_b;
                    carry_d = in_sub ? 1'b1 : in_cin;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                work_d[idx_q] = add_sum;
                carry_d       = add_cout;
                idx_d         = idx_q + IDX_W'(1);
                // Results publish only on completion so the previous answer stays visible meanwhile.
                if (idx_q == LAST_IDX) begin
                    idx_d   = '0;
                    sum_d   = work_d;
                    cout_d  = add_cout;
                    ovf_d   = (a_q[WORDS-1][CHUNK_W-1] == b_q[WORDS-1][CHUNK_W-1]) &&
                              (add_sum[CHUNK_W-1] != a_q[WORDS-1][CHUNK_W-1]);
                    valid_d = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                valid_d = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            work_q  <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            work_q  <= work_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            valid_q <= valid_d;
        end
    end

endmodule

// File: tb/tb_multiword_add_sequencer.sv
// Self-checking bench for multiword_add_sequencer (WORDS=4): directed table,
// backpressure and mid-operation reset sequences, then randomized operations.
module tb_multiword_add_sequencer;

    localparam int WORDS = 4;
    localparam int W     = 16 * WORDS;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_a;
    logic [W-1:0]  in_b;
    logic          in_cin;
    logic          in_sub;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_sum;
    logic          out_cout;
    logic          out_ovf;
    logic          busy;

    int checks;
    int failures;

    typedef struct {
        string        name;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic         sub;
        logic [W-1:0] exp_sum;
        logic         exp_cout;
        logic         exp_ovf;
    } vec_t;

    vec_t vecs[7];

    multiword_add_sequencer #(.WORDS(WORDS)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
        .in_sub    (in_sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .out_ovf   (out_ovf),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkVal(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Whole-word reference: one wide addition, sign rule on the operands as seen by the adder.
    task automatic refModel(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                            input logic sub, output logic [W-1:0] s, output logic co,
                            output logic ov);
        logic [W:0]   full;
        logic [W-1:0] be;
        be   = sub ? ~b : b;
        full = {1'b0, a} + {1'b0, be} + {{W{1'b0}}, (sub ? 1'b1 : cin)};
        s    = full[W-1:0];
        co   = full[W];
        ov   = (a[W-1] == be[W-1]) && (s[W-1] != a[W-1]);
    endtask

    task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic cin, input logic sub);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) begin
            checks++;
            failures++;
            $display("[TB] FAIL in_ready_wait actual=0 required=1");
        end
        in_a     = a;
        in_b     = b;
        in_cin   = cin;
        in_sub   = sub;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        // Operands must have been captured; scramble them to prove it.
        in_a   = {$urandom, $urandom};
        in_b   = {$urandom, $urandom};
        in_cin = ~cin;
        in_sub = ~sub;
    endtask

    task automatic waitResult(input string name);
        int edges;
        edges = 0;
        do begin
            @(posedge clk);
            #1;
            edges++;
        end while (!out_valid && edges < 40);
        checkVal({name, "_latency"}, W'(edges), W'(WORDS));
    endtask

    task automatic checkOutput(input string name, input logic [W-1:0] exp_sum,
                               input logic exp_cout, input logic exp_ovf);
        checkVal({name, "_valid"}, W'(out_valid), W'(1));
        checkVal({name, "_sum"}, out_sum, exp_sum);
        checkVal({name, "_cout"}, W'(out_cout), W'(exp_cout));
        checkVal({name, "_ovf"}, W'(out_ovf), W'(exp_ovf));
    endtask

    task automatic releaseResult(input string name, input logic [W-1:0] exp_sum);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        checkVal({name, "_valid_drop"}, W'(out_valid), W'(0));
        checkVal({name, "_idle_ready"}, W'(in_ready), W'(1));
        checkVal({name, "_sum_kept"}, out_sum, exp_sum);
    endtask

    task automatic runOp(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic cin, input logic sub, input logic [W-1:0] exp_sum,
                         input logic exp_cout, input logic exp_ovf);
        applyStimulus(a, b, cin, sub);
        checkVal({name, "_busy"}, W'(busy), W'(1));
        waitResult(name);
        checkOutput(name, exp_sum, exp_cout, exp_ovf);
        releaseResult(name, exp_sum);
    endtask

    initial begin
        logic [W-1:0] s, ra, rb, pa, pb, held_sum;
        logic         co, ov, rc, rs;
        int           edges;

        checks    = 0;
        failures  = 0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_cin    = 1'b0;
        in_sub    = 1'b0;

        vecs[0] = '{"carry_chunk", 64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 1'b0,
                    64'h0000_0000_0001_0000, 1'b0, 1'b0};
        vecs[1] = '{"full_ripple", 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1'b0,
                    64'h0, 1'b1, 1'b0};
        vecs[2] = '{"sub_borrow", 64'h5, 64'h7, 1'b1, 1'b1,
                    64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0};
        vecs[3] = '{"ovf_add", 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0,
                    64'h8000_0000_0000_0000, 1'b0, 1'b1};
        vecs[4] = '{"ovf_sub", 64'h8000_0000_0000_0000, 64'h1, 1'b0, 1'b1,
                    64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1};
        vecs[5] = '{"small_add", 64'h3, 64'h4, 1'b0, 1'b0, 64'h7, 1'b0, 1'b0};
        vecs[6] = '{"zero_sub", 64'h0, 64'h0, 1'b0, 1'b1, 64'h0, 1'b1, 1'b0};

        rst = 1'b1;
        #12;
        checkVal("rst_out_valid", W'(out_valid), W'(0));
        checkVal("rst_in_ready", W'(in_ready), W'(0));
        checkVal("rst_busy", W'(busy), W'(0));
        checkVal("rst_sum", out_sum, '0);
        checkVal("rst_cout", W'(out_cout), W'(0));
        checkVal("rst_ovf", W'(out_ovf), W'(0));
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkVal("rel_in_ready", W'(in_ready), W'(1));

        for (int i = 0; i < 7; i++) begin
            runOp(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub,
                  vecs[i].exp_sum, vecs[i].exp_cout, vecs[i].exp_ovf);
        end

        // Backpressure: result held for 5 cycles while a competing request is offered.
        applyStimulus(64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 1'b0);
        waitResult("bp");
        held_sum = 64'h0000_0000_0001_0000;
        pa = 64'h1234_5678_9ABC_DEF0;
        pb = 64'h0FED_CBA9_8765_4321;
        @(negedge clk);
        in_a     = pa;
        in_b     = pb;
        in_cin   = 1'b1;
        in_sub   = 1'b0;
        in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            checkOutput($sformatf("bp_hold%0d", c), held_sum, 1'b0, 1'b0);
            checkVal($sformatf("bp_in_ready%0d", c), W'(in_ready), W'(0));
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        checkVal("bp_drop_valid", W'(out_valid), W'(0));
        checkVal("bp_not_taken", W'(busy), W'(0));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        checkVal("bp_taken", W'(busy), W'(1));
        edges = 0;
        do begin
            @(posedge clk);
            #1;
            edges++;
        end while (!out_valid && edges < 40);
        checkVal("bp_latency", W'(edges), W'(WORDS));
        refModel(pa, pb, 1'b1, 1'b0, s, co, ov);
        checkOutput("bp_next", s, co, ov);
        releaseResult("bp_next", s);

        // Reset two chunk edges into an operation.
        applyStimulus(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        checkVal("midrst_valid", W'(out_valid), W'(0));
        checkVal("midrst_busy", W'(busy), W'(0));
        checkVal("midrst_in_ready", W'(in_ready), W'(0));
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        checkVal("midrst_sum", out_sum, '0);
        runOp("after_rst", 64'h3, 64'h4, 1'b0, 1'b0, 64'h7, 1'b0, 1'b0);

        for (int n = 0; n < 40; n++) begin
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            if (n % 4 == 1) ra[47:0] = 48'hFFFF_FFFF_FFFF;
            if (n % 4 == 2) rb = ~ra;
            rc = 1'(($urandom >> 3) & 1);
            rs = 1'(($urandom >> 7) & 1);
            refModel(ra, rb, rc, rs, s, co, ov);
            runOp($sformatf("rand%0d", n), ra, rb, rc, rs, s, co, ov);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
